// File: rtl/wishbone_arbiter_2m.sv
// Two-master / one-slave Wishbone classic arbiter: round-robin grant, CYC lock,
// and a watchdog that aborts a stalled strobe with a one-cycle error to the owner.
module wishbone_arbiter_2m #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_ack_i,
  output logic [1:0]        gnt_o
);

  localparam bit          WD_EN = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CNT_W = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(WD_EN ? (TIMEOUT_CYCLES - 32'd1) : 32'd0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_ABORT = 2'd2
  } state_e;

  state_e           state_q;
  logic [1:0]       gnt_q;
  logic             last_q;   // index of the previous owner
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       err_q;

  logic              own_c;
  logic              sel1_c;
  logic              own_cyc_c;
  logic              own_stb_c;
  logic              own_we_c;
  logic [ADDR_W-1:0] own_addr_c;
  logic [DATA_W-1:0] own_data_c;
  logic              timeout_c;

  // Owner-selected request lines; slave side is only driven while in OWN.
  always_comb begin
    own_c      = (state_q == ST_OWN);
    sel1_c     = gnt_q[1];
    own_cyc_c  = sel1_c ? m1_cyc_i  : m0_cyc_i;
    own_stb_c  = sel1_c ? m1_stb_i  : m0_stb_i;
    own_we_c   = sel1_c ? m1_we_i   : m0_we_i;
    own_addr_c = sel1_c ? m1_addr_i : m0_addr_i;
    own_data_c = sel1_c ? m1_data_i : m0_data_i;

    s_cyc_o  = own_c & own_cyc_c;
    s_stb_o  = own_c & own_cyc_c & own_stb_c;
    s_we_o   = own_c & own_cyc_c & own_we_c;
    s_addr_o = own_c ? own_addr_c : '0;
    s_data_o = own_c ? own_data_c : '0;

    m0_ack_o  = s_ack_i & s_stb_o & gnt_q[0];
    m1_ack_o  = s_ack_i & s_stb_o & gnt_q[1];
    m0_data_o = (own_c && gnt_q[0]) ? s_data_i : '0;
    m1_data_o = (own_c && gnt_q[1]) ? s_data_i : '0;
    m0_err_o  = err_q[0];
    m1_err_o  = err_q[1];
    gnt_o     = gnt_q;

    // An ack in the expiring cycle wins over the timeout.
    timeout_c = WD_EN && s_stb_o && !s_ack_i && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 2'b00;
    end else begin
      err_q <= 2'b00;
      unique case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
            gnt_q   <= 2'b01;
            state_q <= ST_OWN;
          end else if (m1_cyc_i) begin
            gnt_q   <= 2'b10;
            state_q <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (!own_cyc_c) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            last_q  <= sel1_c;
            cnt_q   <= '0;
          end else if (timeout_c) begin
            state_q <= ST_ABORT;
            err_q   <= gnt_q;
            cnt_q   <= '0;
          end else if (WD_EN && s_stb_o && !s_ack_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        ST_ABORT: begin
          if (!own_cyc_c) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            last_q  <= sel1_c;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= 2'b00;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter_2m.sv
// Directed self-checking bench for wishbone_arbiter_2m (watchdog set to 8 cycles).
module tb_wishbone_arbiter_2m;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              m0_cyc_i, m0_stb_i, m0_we_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_data_i, m0_data_o;
  logic              m0_ack_o, m0_err_o;
  logic              m1_cyc_i, m1_stb_i, m1_we_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_data_i, m1_data_o;
  logic              m1_ack_o, m1_err_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [ADDR_W-1:0] s_addr_o;
  logic [DATA_W-1:0] s_data_o, s_data_i;
  logic              s_ack_i;
  logic [1:0]        gnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  wishbone_arbiter_2m #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i),
    .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_data_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_data_i = '0;
    s_ack_i  = 0; s_data_i = '0;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    clear_inputs();
    m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 1;
    tick();
    #1;
    n_checks++;
    if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || s_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_bus: gnt=%b cyc=%b stb=%b we=%b, required 00 0 0 0",
               gnt_o, s_cyc_o, s_stb_o, s_we_o);
    end
    n_checks++;
    if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0000 || s_addr_o !== '0) begin
      n_fail++;
      $display("FAIL reset_resp: ack/err=%b addr=%h, required 0000 / 0",
               {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, s_addr_o);
    end
    apply_reset();
  endtask

  task automatic test_single_read();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_addr_i = 32'h10;
    #1;
    n_checks++;
    if (gnt_o !== 2'b00) begin
      n_fail++; $display("FAIL t1_no_early_gnt: gnt=%b required 00", gnt_o);
    end
    tick();
    n_checks++;
    if (gnt_o !== 2'b01 || s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || s_addr_o !== 32'h10) begin
      n_fail++;
      $display("FAIL t1_grant: gnt=%b cyc=%b stb=%b addr=%h, required 01 1 1 00000010",
               gnt_o, s_cyc_o, s_stb_o, s_addr_o);
    end
    s_ack_i = 1; s_data_i = 64'hDEAD_BEEF;
    #1;
    n_checks++;
    if (m0_ack_o !== 1'b1 || m0_data_o !== 64'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL t1_read_ack: ack=%b data=%h, required 1 00000000deadbeef", m0_ack_o, m0_data_o);
    end
    n_checks++;
    if (m1_ack_o !== 1'b0 || m1_data_o !== '0 || m0_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_other_quiet: m1_ack=%b m1_data=%h m0_err=%b, required 0 0 0",
               m1_ack_o, m1_data_o, m0_err_o);
    end
    tick();
    clear_inputs();
    tick();
    n_checks++;
    if (gnt_o !== 2'b00) begin
      n_fail++; $display("FAIL t1_release: gnt=%b required 00", gnt_o);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h100 + 32'(i);
      m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h200 + 32'(i);
      tick();
      n_checks++;
      if (gnt_o !== exp_gnt) begin
        n_fail++; $display("FAIL t2_gnt[%0d]: gnt=%b required %b", i, gnt_o, exp_gnt);
      end
      s_ack_i = 1; s_data_i = 64'h1234_0000 + 64'(i);
      #1;
      n_checks++;
      if (m0_ack_o !== exp_gnt[0] || m1_ack_o !== exp_gnt[1]) begin
        n_fail++;
        $display("FAIL t2_ack[%0d]: m0_ack=%b m1_ack=%b, required %b %b",
                 i, m0_ack_o, m1_ack_o, exp_gnt[0], exp_gnt[1]);
      end
      n_checks++;
      if (s_addr_o !== (exp_gnt[0] ? 32'h100 + 32'(i) : 32'h200 + 32'(i))) begin
        n_fail++; $display("FAIL t2_addr[%0d]: addr=%h wrong master routed", i, s_addr_o);
      end
      tick();
      clear_inputs();
      tick();
      n_checks++;
      if (gnt_o !== 2'b00) begin
        n_fail++; $display("FAIL t2_idle_gap[%0d]: gnt=%b required 00", i, gnt_o);
      end
    end
  endtask

  task automatic test_lock();
    m1_cyc_i = 1;
    tick();
    n_checks++;
    if (gnt_o !== 2'b10) begin
      n_fail++; $display("FAIL t3_m1_gnt: gnt=%b required 10", gnt_o);
    end
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'hAAAA;
    for (int i = 0; i < 3; i++) begin
      m1_stb_i = 1; m1_we_i = 1; m1_addr_i = 32'h40 + 32'(8 * i);
      m1_data_i = 64'hCAFE_0000_0000_0000 + 64'(i);
      s_ack_i = 1;
      #1;
      n_checks++;
      if (gnt_o !== 2'b10 || s_we_o !== 1'b1 || s_addr_o !== 32'h40 + 32'(8 * i)
          || s_data_o !== 64'hCAFE_0000_0000_0000 + 64'(i)) begin
        n_fail++;
        $display("FAIL t3_write[%0d]: gnt=%b we=%b addr=%h data=%h", i, gnt_o, s_we_o, s_addr_o, s_data_o);
      end
      n_checks++;
      if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin
        n_fail++;
        $display("FAIL t3_hold_off[%0d]: m1_ack=%b m0_ack=%b, required 1 0", i, m1_ack_o, m0_ack_o);
      end
      tick();
    end
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; s_ack_i = 0;
    tick();
    n_checks++;
    if (gnt_o !== 2'b00 || m0_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL t3_idle: gnt=%b m0_ack=%b, required 00 0", gnt_o, m0_ack_o);
    end
    tick();
    n_checks++;
    if (gnt_o !== 2'b01 || s_addr_o !== 32'hAAAA) begin
      n_fail++; $display("FAIL t3_m0_gnt: gnt=%b addr=%h, required 01 0000aaaa", gnt_o, s_addr_o);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_watchdog();
    int err_count;
    err_count = 0;
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h80;
    tick();
    n_checks++;
    if (gnt_o !== 2'b01 || s_stb_o !== 1'b1) begin
      n_fail++; $display("FAIL t4_gnt: gnt=%b stb=%b, required 01 1", gnt_o, s_stb_o);
    end
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (m0_err_o === 1'b1) err_count++;
    end
    n_checks++;
    if (err_count != 0 || s_stb_o !== 1'b1) begin
      n_fail++; $display("FAIL t4_early_err: errs=%0d stb=%b, required 0 1", err_count, s_stb_o);
    end
    tick();
    n_checks++;
    if (m0_err_o !== 1'b1 || m1_err_o !== 1'b0 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_timeout: m0_err=%b m1_err=%b cyc=%b stb=%b, required 1 0 0 0",
               m0_err_o, m1_err_o, s_cyc_o, s_stb_o);
    end
    tick();
    n_checks++;
    if (m0_err_o !== 1'b0) begin
      n_fail++; $display("FAIL t4_pulse_width: err=%b required 0", m0_err_o);
    end
    s_ack_i = 1; s_data_i = 64'h5555;
    #1;
    n_checks++;
    if (m0_ack_o !== 1'b0 || s_cyc_o !== 1'b0) begin
      n_fail++; $display("FAIL t4_late_ack: ack=%b cyc=%b, required 0 0", m0_ack_o, s_cyc_o);
    end
    tick();
    clear_inputs();
    tick();
    n_checks++;
    if (gnt_o !== 2'b00 || m0_err_o !== 1'b0) begin
      n_fail++; $display("FAIL t4_exit: gnt=%b err=%b, required 00 0", gnt_o, m0_err_o);
    end
  endtask

  task automatic test_ack_vs_timeout();
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h90;
    tick();
    for (int i = 0; i < 7; i++) tick();
    s_ack_i = 1; s_data_i = 64'h0BAD_F00D;
    #1;
    n_checks++;
    if (m0_ack_o !== 1'b1 || m0_err_o !== 1'b0 || m0_data_o !== 64'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL t5_ack_wins: ack=%b err=%b data=%h, required 1 0 000000000badf00d",
               m0_ack_o, m0_err_o, m0_data_o);
    end
    tick();
    m0_stb_i = 0; s_ack_i = 0;
    #1;
    n_checks++;
    if (m0_err_o !== 1'b0 || s_cyc_o !== 1'b1 || gnt_o !== 2'b01) begin
      n_fail++;
      $display("FAIL t5_no_err: err=%b cyc=%b gnt=%b, required 0 1 01", m0_err_o, s_cyc_o, gnt_o);
    end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h30;
    tick();
    n_checks++;
    if (gnt_o !== 2'b01 || s_cyc_o !== 1'b1) begin
      n_fail++; $display("FAIL t6_pre_gnt: gnt=%b cyc=%b, required 01 1", gnt_o, s_cyc_o);
    end
    s_ack_i = 1;
    #2;
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || gnt_o !== 2'b00 || m0_ack_o !== 1'b0
        || m0_err_o !== 1'b0 || s_addr_o !== '0) begin
      n_fail++;
      $display("FAIL t6_async: cyc=%b stb=%b gnt=%b ack=%b err=%b addr=%h, required all 0",
               s_cyc_o, s_stb_o, gnt_o, m0_ack_o, m0_err_o, s_addr_o);
    end
    s_ack_i = 0;
    m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    rst_i = 1'b0;
    #1;
    n_checks++;
    if (gnt_o !== 2'b00) begin
      n_fail++; $display("FAIL t6_held: gnt=%b required 00", gnt_o);
    end
    tick();
    n_checks++;
    if (gnt_o !== 2'b01) begin
      n_fail++; $display("FAIL t6_tie_after_reset: gnt=%b required 01", gnt_o);
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_watchdog();
    test_ack_vs_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
